carrier_receiver: RTL and testbench



---
 rtl/carrier_pkg.sv | 14 +
 rtl/carrier_edge_detector.sv | 22 ++
 rtl/carrier_receiver.sv | 128 ++++++++++++
 tb/tb_carrier_receiver.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/carrier_pkg.sv
// carrier_pkg: shared timing helpers and types for the 4-phase carrier link
package carrier_pkg;
  localparam int SYMBOL_W = 2;
  typedef enum logic [1:0] {ST_IDLE, ST_ACQUIRE, ST_LOCKED} carrier_state_t;
  function automatic int interval_of(real clk_hz, real tgt_hz);
    return $rtoi(clk_hz / tgt_hz / 2.0);
  endfunction
  function automatic int slot_target(int k, int interval);
    return k == 0 ? 0 : k == 1 ? interval / 2 : k == 2 ? interval / 4 : 3 * interval / 4;
  endfunction
  function automatic int edge_delay(int sync_stages, int extra_delay, int interval);
    return (sync_stages + 1 + extra_delay) % interval;
  endfunction
endpackage

// File: rtl/carrier_edge_detector.sv
// carrier_edge_detector: synchronises the RX line and pulses on either transition
module carrier_edge_detector #(
  parameter int SYNC_STAGES = 2
) (
  input  logic RST,
  input  logic CLK,
  input  logic i_rx,
  output logic o_edge
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic r_prev;
  // shift RX through the synchroniser and keep a one-cycle-old copy of its output
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_rx};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  assign o_edge = r_sync[SYNC_STAGES-1] ^ r_prev;
endmodule

// File: rtl/carrier_receiver.sv
// carrier_receiver: demodulates the 4-phase carrier into confirmed 2-bit symbols
module carrier_receiver
  import carrier_pkg::*;
#(
  parameter real CLOCK_FREQUENCY  = 100000000.0,
  parameter real TARGET_FREQUENCY = 10000000.0,
  parameter int  SYNC_STAGES      = 2,
  parameter int  EXTRA_DELAY      = 0,
  parameter int  CONFIRM          = 3,
  parameter int  TIMEOUT_PERIODS  = 4
) (
  input  logic                RST,
  input  logic                CLK,
  input  logic                RX,
  output logic [SYMBOL_W-1:0] VALUE,
  output logic                VALID,
  output logic                CARRIER
);
  localparam int INTERVAL   = interval_of(CLOCK_FREQUENCY, TARGET_FREQUENCY);
  localparam int EDGE_DELAY = edge_delay(SYNC_STAGES, EXTRA_DELAY, INTERVAL);
  localparam int CW         = INTERVAL > 1 ? $clog2(INTERVAL) : 1;
  localparam int SW         = CW + 1;
  localparam int GAP_MAX    = TIMEOUT_PERIODS * INTERVAL;
  localparam int GW         = $clog2(GAP_MAX + 1);
  localparam int AW         = $clog2(CONFIRM + 1);

  logic                w_edge;
  logic [CW-1:0]       r_cnt;
  logic [SW-1:0]       w_sum;
  logic [SW-1:0]       w_c;
  logic [SYMBOL_W-1:0] w_est;
  logic [SYMBOL_W-1:0] r_est;
  logic                r_est_valid;
  logic [SYMBOL_W-1:0] r_last_est;
  logic [SYMBOL_W-1:0] w_last_n;
  logic [AW-1:0]       r_agree;
  logic [AW-1:0]       w_agree_n;
  logic [GW-1:0]       r_gap;
  logic                w_timeout;
  logic                w_match;
  logic                w_commit;
  logic [SYMBOL_W-1:0] r_value;
  logic                r_valid;
  carrier_state_t      r_state;
  carrier_state_t      w_state_n;

  carrier_edge_detector #(.SYNC_STAGES(SYNC_STAGES)) u_edge (
    .RST   (RST),
    .CLK   (CLK),
    .i_rx  (RX),
    .o_edge(w_edge)
  );

  function automatic logic [SYMBOL_W-1:0] quantise(int c);
    int best;
    int d;
    logic [SYMBOL_W-1:0] k_best;
    best   = INTERVAL;
    k_best = '0;
    for (int k = 0; k < 4; k++) begin
      d = c > slot_target(k, INTERVAL) ? c - slot_target(k, INTERVAL) : slot_target(k, INTERVAL) - c;
      d = d < INTERVAL - d ? d : INTERVAL - d;
      if (d < best) begin
        best   = d;
        k_best = SYMBOL_W'(k);
      end
    end
    return k_best;
  endfunction

  assign w_sum     = {1'b0, r_cnt} + SW'(EDGE_DELAY);
  assign w_c       = w_sum >= SW'(INTERVAL) ? w_sum - SW'(INTERVAL) : w_sum;
  assign w_est     = quantise(int'(w_c));
  assign w_timeout = !w_edge && r_gap == GW'(GAP_MAX - 1);

  // phase reference, edge-gap timer and the registered per-edge slot estimate
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      r_cnt       <= CW'(INTERVAL - 1);
      r_gap       <= '0;
      r_est       <= '0;
      r_est_valid <= 1'b0;
    end else begin
      r_cnt       <= r_cnt == '0 ? CW'(INTERVAL - 1) : r_cnt - 1'b1;
      r_gap       <= w_edge ? '0 : r_gap == GW'(GAP_MAX) ? r_gap : r_gap + 1'b1;
      r_est       <= w_edge ? w_est : r_est;
      r_est_valid <= w_edge;
    end

  // agreement counting, commit decision and lock state transitions
  always_comb begin
    w_match   = r_agree != '0 && r_est == r_last_est;
    w_agree_n = r_agree;
    w_last_n  = r_last_est;
    w_commit  = 1'b0;
    w_state_n = r_state;
    if (r_est_valid) begin
      w_agree_n = !w_match ? AW'(1) : r_agree == AW'(CONFIRM) ? r_agree : r_agree + 1'b1;
      w_last_n  = w_match ? r_last_est : r_est;
      w_commit  = w_agree_n == AW'(CONFIRM) && !(w_match && r_agree == AW'(CONFIRM));
    end
    if (w_timeout) begin
      w_state_n = ST_IDLE;
      w_agree_n = '0;
    end else if (w_commit) w_state_n = ST_LOCKED;
    else if (r_state == ST_IDLE && w_edge) w_state_n = ST_ACQUIRE;
  end

  // lock state, agreement history and committed symbol registers
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      r_state    <= ST_IDLE;
      r_agree    <= '0;
      r_last_est <= '0;
      r_value    <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_agree    <= w_agree_n;
      r_last_est <= w_last_n;
      r_value    <= w_commit ? r_est : r_value;
      r_valid    <= w_commit;
    end

  assign VALUE   = r_value;
  assign VALID   = r_valid;
  assign CARRIER = r_state == ST_LOCKED;
endmodule

// File: tb/tb_carrier_receiver.sv
// tb_carrier_receiver: directed loopback bench against transmitter models at INTERVAL 5 and 20
module tb_carrier_receiver;
  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       tx_a, tx_b, rx_man, use_man, en_a, en_b, rx_a;
  logic [1:0] val_a, val_b;
  logic [2:0] cnt_a;
  logic [4:0] cnt_b;
  logic [1:0] value_a, value_b, value_c;
  logic       valid_a, valid_b, valid_c, carrier_a, carrier_b, carrier_c;
  int         tgt5[4]  = '{0, 2, 1, 3};
  int         tgt20[4] = '{0, 10, 5, 15};
  int         n_pass = 0;
  int         n_total = 0;

  assign rx_a = use_man ? rx_man : tx_a;

  carrier_receiver dut_a (
    .RST(RST), .CLK(CLK), .RX(rx_a), .VALUE(value_a), .VALID(valid_a), .CARRIER(carrier_a)
  );
  carrier_receiver #(.TARGET_FREQUENCY(2500000.0)) dut_b (
    .RST(RST), .CLK(CLK), .RX(tx_b), .VALUE(value_b), .VALID(valid_b), .CARRIER(carrier_b)
  );
  carrier_receiver #(.TARGET_FREQUENCY(2500000.0), .EXTRA_DELAY(1)) dut_c (
    .RST(RST), .CLK(CLK), .RX(tx_b), .VALUE(value_c), .VALID(valid_c), .CARRIER(carrier_c)
  );

  always #5 CLK = ~CLK;

  // transmitter model, INTERVAL 5: toggles when its reload counter hits the slot target
  always @(posedge CLK or posedge RST)
    if (RST) begin
      cnt_a <= 3'd4;
      tx_a  <= 1'b0;
    end else begin
      cnt_a <= cnt_a == 3'd0 ? 3'd4 : cnt_a - 3'd1;
      if (en_a && int'(cnt_a) == tgt5[val_a]) tx_a <= ~tx_a;
    end

  // transmitter model, INTERVAL 20
  always @(posedge CLK or posedge RST)
    if (RST) begin
      cnt_b <= 5'd19;
      tx_b  <= 1'b0;
    end else begin
      cnt_b <= cnt_b == 5'd0 ? 5'd19 : cnt_b - 5'd1;
      if (en_b && int'(cnt_b) == tgt20[val_b]) tx_b <= ~tx_b;
    end

  task automatic await_commit(input int budget, output bit seen, output int chgs, output int lat,
                              output int low);
    logic prev;
    int last;
    seen = 0; chgs = 0; lat = -1; last = 0; low = 0; prev = rx_a;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge CLK);
      if (rx_a !== prev) begin chgs++; last = i; prev = rx_a; end
      if (carrier_a !== 1'b1) low++;
      if (valid_a === 1'b1) begin seen = 1; lat = i - last; end
    end
  endtask

  task automatic count_valid(input int cycles, output int nv, output int low);
    nv = 0; low = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge CLK);
      if (valid_a === 1'b1) nv++;
      if (carrier_a !== 1'b1) low++;
    end
  endtask

  task automatic test_reset;
    RST = 1'b1; use_man = 1'b1; rx_man = 1'b0;
    en_a = 1'b0; en_b = 1'b0; val_a = 2'd0; val_b = 2'd0;
    for (int i = 0; i < 6; i++) begin rx_man = i[0]; @(negedge CLK); end
    n_total++; if (value_a !== 2'd0) $display("FAIL reset_value got %0d want 0", value_a); else n_pass++;
    n_total++; if (valid_a !== 1'b0) $display("FAIL reset_valid got %0b want 0", valid_a); else n_pass++;
    n_total++; if (carrier_a !== 1'b0) $display("FAIL reset_carrier got %0b want 0", carrier_a); else n_pass++;
    rx_man = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    #1;
    n_total++; if (dut_a.r_cnt !== 3'd4) $display("FAIL reset_cnt got %0d want 4", dut_a.r_cnt); else n_pass++;
    @(negedge CLK);
    n_total++; if (dut_a.r_cnt !== 3'd3) $display("FAIL reset_cnt_step got %0d want 3", dut_a.r_cnt); else n_pass++;
    use_man = 1'b0;
  endtask

  task automatic test_loopback;
    bit seen; int chgs, lat, low, nv;
    val_a = 2'd2; en_a = 1'b1;
    await_commit(60, seen, chgs, lat, low);
    n_total++; if (!seen) $display("FAIL loop_seen got 0 want 1"); else n_pass++;
    n_total++; if (value_a !== 2'd2) $display("FAIL loop_value got %0d want 2", value_a); else n_pass++;
    n_total++; if (carrier_a !== 1'b1) $display("FAIL loop_carrier got %0b want 1", carrier_a); else n_pass++;
    n_total++; if (chgs != 3) $display("FAIL loop_edges got %0d want 3", chgs); else n_pass++;
    n_total++; if (lat != 4) $display("FAIL loop_latency got %0d want 4", lat); else n_pass++;
    @(negedge CLK);
    n_total++; if (valid_a !== 1'b0) $display("FAIL loop_pulse got %0b want 0", valid_a); else n_pass++;
    count_valid(250, nv, low);
    n_total++; if (nv != 0) $display("FAIL loop_extra_valid got %0d want 0", nv); else n_pass++;
    n_total++; if (low != 0) $display("FAIL loop_carrier_hold got %0d low cycles want 0", low); else n_pass++;
  endtask

  task automatic test_switch;
    bit seen; int chgs, lat, low, nv, low2;
    val_a = 2'd1;
    repeat (2) @(negedge CLK);
    rx_man = ~rx_a; use_man = 1'b1;
    @(negedge CLK);
    use_man = 1'b0;
    await_commit(80, seen, chgs, lat, low);
    n_total++; if (!seen) $display("FAIL switch_seen got 0 want 1"); else n_pass++;
    n_total++; if (value_a !== 2'd1) $display("FAIL switch_value got %0d want 1", value_a); else n_pass++;
    n_total++; if (low != 0) $display("FAIL switch_carrier got %0d low cycles want 0", low); else n_pass++;
    count_valid(50, nv, low2);
    n_total++; if (nv != 0) $display("FAIL switch_extra_valid got %0d want 0", nv); else n_pass++;
    n_total++; if (low2 != 0) $display("FAIL switch_carrier_after got %0d low cycles want 0", low2); else n_pass++;
  endtask

  task automatic test_timeout;
    bit seen; int chgs, lat, low, fall;
    logic prev;
    prev = rx_a;
    for (int i = 0; i < 20 && rx_a === prev; i++) @(negedge CLK);
    en_a = 1'b0;
    fall = -1;
    for (int i = 1; i < 40 && fall < 0; i++) begin
      @(negedge CLK);
      if (carrier_a === 1'b0) fall = i;
    end
    n_total++; if (fall != 23) $display("FAIL timeout_fall got %0d want 23", fall); else n_pass++;
    n_total++; if (value_a !== 2'd1) $display("FAIL timeout_value_held got %0d want 1", value_a); else n_pass++;
    en_a = 1'b1;
    await_commit(60, seen, chgs, lat, low);
    n_total++; if (!seen) $display("FAIL reenable_seen got 0 want 1"); else n_pass++;
    n_total++; if (value_a !== 2'd1) $display("FAIL reenable_value got %0d want 1", value_a); else n_pass++;
    n_total++; if (chgs != 3) $display("FAIL reenable_edges got %0d want 3", chgs); else n_pass++;
    n_total++; if (lat != 4) $display("FAIL reenable_latency got %0d want 4", lat); else n_pass++;
  endtask

  task automatic test_interval20;
    bit sb, sc;
    logic [1:0] gb, gc;
    en_b = 1'b1;
    for (int v = 0; v < 4; v++) begin
      val_b = 2'(v); sb = 0; sc = 0; gb = 2'd0; gc = 2'd0;
      for (int i = 0; i < 300 && !(sb && sc); i++) begin
        @(negedge CLK);
        if (valid_b === 1'b1 && !sb) begin sb = 1; gb = value_b; end
        if (valid_c === 1'b1 && !sc) begin sc = 1; gc = value_c; end
      end
      n_total++; if (!sb || gb !== 2'(v)) $display("FAIL i20_value seen=%0b got %0d want %0d", sb, gb, v); else n_pass++;
      n_total++; if (!sc || gc !== 2'(v)) $display("FAIL i20_extra_value seen=%0b got %0d want %0d", sc, gc, v); else n_pass++;
    end
    n_total++; if (carrier_b !== 1'b1) $display("FAIL i20_carrier got %0b want 1", carrier_b); else n_pass++;
    n_total++; if (carrier_c !== 1'b1) $display("FAIL i20_extra_carrier got %0b want 1", carrier_c); else n_pass++;
  endtask

  task automatic test_reset_locked;
    bit seen; int chgs, lat, low;
    @(negedge CLK);
    RST = 1'b1;
    #1;
    n_total++; if (value_a !== 2'd0) $display("FAIL rst_lock_value got %0d want 0", value_a); else n_pass++;
    n_total++; if (valid_a !== 1'b0) $display("FAIL rst_lock_valid got %0b want 0", valid_a); else n_pass++;
    n_total++; if (carrier_a !== 1'b0) $display("FAIL rst_lock_carrier got %0b want 0", carrier_a); else n_pass++;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    await_commit(60, seen, chgs, lat, low);
    n_total++; if (!seen) $display("FAIL reacq_seen got 0 want 1"); else n_pass++;
    n_total++; if (value_a !== 2'd1) $display("FAIL reacq_value got %0d want 1", value_a); else n_pass++;
    n_total++; if (chgs != 3) $display("FAIL reacq_edges got %0d want 3", chgs); else n_pass++;
    n_total++; if (lat != 4) $display("FAIL reacq_latency got %0d want 4", lat); else n_pass++;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired after %0d checks", n_total);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_loopback();
    test_switch();
    test_timeout();
    test_interval20();
    test_reset_locked();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
